// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - table-driven melody player driving a square-wave generator's frequency_control
// Optional feature macro: SEQ_LOOP_EN (adds the loop input to replay from entry 0 at the end of a sequence)
module note_sequencer #(
    parameter int FREQ_WIDTH = 8,
    parameter int DUR_WIDTH  = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int BEAT_DIV   = 1000,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
`ifdef SEQ_LOOP_EN
    input  logic                  loop,
`endif
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [FREQ_WIDTH-1:0] wr_freq,
    input  logic [DUR_WIDTH-1:0]  wr_dur,
    output logic [FREQ_WIDTH-1:0] frequency_control,
    output logic [ADDR_WIDTH-1:0] note_index,
    output logic                  busy,
    output logic                  done
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int BEAT_W = $clog2(BEAT_DIV) + 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1) + 1;
    localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BEAT_DIV - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [FREQ_WIDTH-1:0]   freq_q, freq_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [DUR_WIDTH-1:0]    beats_q, beats_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    advance, end_seq, loop_en;
    logic [FREQ_WIDTH-1:0]   ent_freq;
    logic [DUR_WIDTH-1:0]    ent_dur;

    logic [FREQ_WIDTH+DUR_WIDTH-1:0] note_tbl [DEPTH];

`ifdef SEQ_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    // Table survives reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (reset && state_q == S_IDLE && wr_en) begin
            note_tbl[wr_addr] <= {wr_freq, wr_dur};
        end
    end

    assign {ent_freq, ent_dur} = note_tbl[idx_q];

    always_comb begin
        state_d    = state_q;
        freq_d     = freq_q;
        idx_d      = idx_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        done_d     = 1'b0;
        advance    = 1'b0;
        end_seq    = 1'b0;
        case (state_q)
            S_IDLE: begin
                freq_d = '0;
                if (start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end
            end
            S_FETCH: begin
                if (ent_dur == '0) begin
                    end_seq = 1'b1;
                end else begin
                    state_d    = S_PLAY;
                    freq_d     = ent_freq;
                    beats_d    = ent_dur;
                    beat_cnt_d = '0;
                end
            end
            S_PLAY: begin
                if (beat_cnt_q == BEAT_LAST) begin
                    beat_cnt_d = '0;
                    if (beats_q == DUR_WIDTH'(1)) begin
                        freq_d = '0;
                        if (GAP_CYCLES > 0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        beats_d = beats_q - 1'b1;
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The last table slot acts as an implicit end marker; the index never wraps.
        if (advance) begin
            if (idx_q == LAST_ADDR) begin
                end_seq = 1'b1;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_FETCH;
            end
        end
        if (end_seq) begin
            if (loop_en) begin
                idx_d   = '0;
                state_d = S_FETCH;
            end else begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        end
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            freq_d  = '0;
            idx_d   = idx_q;
            done_d  = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            freq_q     <= '0;
            idx_q      <= '0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            freq_q     <= freq_d;
            idx_q      <= idx_d;
            beats_q    <= beats_d;
            beat_cnt_q <= beat_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign frequency_control = freq_q;
    assign note_index        = idx_q;
    assign busy              = busy_q;
    assign done              = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench for note_sequencer (BEAT_DIV=4, GAP_CYCLES=2)
module tb_note_sequencer;
    localparam int FW = 8;
    localparam int DW = 4;
    localparam int AW = 4;
    localparam int BD = 4;
    localparam int GC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop, wr_en;
    logic [AW-1:0] wr_addr;
    logic [FW-1:0] wr_freq;
    logic [DW-1:0] wr_dur;
    logic [FW-1:0] frequency_control;
    logic [AW-1:0] note_index;
    logic          busy, done;
`ifdef SEQ_LOOP_EN
    logic          loop;
`endif

    int checks = 0;
    int errors = 0;
    int exp_f[$];

    note_sequencer #(
        .FREQ_WIDTH(FW), .DUR_WIDTH(DW), .ADDR_WIDTH(AW), .BEAT_DIV(BD), .GAP_CYCLES(GC)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .start(start),
        .stop(stop),
`ifdef SEQ_LOOP_EN
        .loop(loop),
`endif
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_freq(wr_freq),
        .wr_dur(wr_dur),
        .frequency_control(frequency_control),
        .note_index(note_index),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int a, input int f, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_freq = FW'(f); wr_dur = DW'(d);
        tick();
        wr_en = 1'b0;
    endtask

    // One note as seen after its FETCH cycle: play, gap, then the next FETCH.
    task automatic push_note(input int f, input int d);
        for (int i = 0; i < d * BD; i++) exp_f.push_back(f);
        for (int i = 0; i < GC; i++) exp_f.push_back(0);
        exp_f.push_back(0);
    endtask

    task automatic run_exp(input string tag);
        for (int i = 0; i < exp_f.size(); i++) begin
            tick();
            chk($sformatf("%s_freq%0d", tag, i), frequency_control, exp_f[i]);
            chk($sformatf("%s_done%0d", tag, i), done, 0);
            chk($sformatf("%s_busy%0d", tag, i), busy, 1);
        end
        exp_f.delete();
    endtask

    task automatic start_play(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_fetch_busy"}, busy, 1);
        chk({tag, "_fetch_freq"}, frequency_control, 0);
        chk({tag, "_fetch_idx"}, note_index, 0);
    endtask

    task automatic done_check(input string tag, input int idx);
        tick();
        chk({tag, "_done_pulse"}, done, 1);
        chk({tag, "_done_busy"}, busy, 1);
        chk({tag, "_done_freq"}, frequency_control, 0);
        chk({tag, "_done_idx"}, note_index, idx);
        tick();
        chk({tag, "_after_done"}, done, 0);
        chk({tag, "_after_busy"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_freq = '0; wr_dur = '0;
`ifdef SEQ_LOOP_EN
        loop = 1'b0;
`endif
        tick();
        tick();
        chk("rst_freq", frequency_control, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", note_index, 0);
        rst_n = 1'b1;

        // short table with gap and end marker
        wr(0, 10, 2);
        wr(1, 20, 1);
        wr(2, 0, 0);
        start_play("short");
        push_note(10, 2);
        push_note(20, 1);
        run_exp("short");
        done_check("short", 2);

        // stop on the 5th PLAY cycle
        wr(0, 50, 3);
        wr(1, 0, 0);
        start_play("stop");
        for (int i = 0; i < 5; i++) tick();
        chk("stop_play5_freq", frequency_control, 50);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_freq", frequency_control, 0);
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        chk("stop_idx", note_index, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stop_no_done", done, 0);
        end

        // writes and start ignored while busy
        wr(0, 10, 2);
        wr(1, 20, 1);
        wr(2, 0, 0);
        start_play("busy");
        tick();
        chk("busy_play1", frequency_control, 10);
        wr_en = 1'b1; wr_addr = 4'd1; wr_freq = 8'd99; wr_dur = 4'd5; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        chk("busy_play2", frequency_control, 10);
        for (int i = 0; i < 6; i++) exp_f.push_back(10);
        exp_f.push_back(0); exp_f.push_back(0); exp_f.push_back(0);
        push_note(20, 1);
        run_exp("busy");
        done_check("busy", 2);
        start_play("replay");
        push_note(10, 2);
        push_note(20, 1);
        run_exp("replay");
        done_check("replay", 2);

        // full table; last write coincides with start in IDLE
        for (int i = 0; i < 15; i++) wr(i, i + 1, 1);
        wr_en = 1'b1; wr_addr = 4'd15; wr_freq = 8'd16; wr_dur = 4'd1;
        start_play("full");
        wr_en = 1'b0;
        for (int i = 0; i < 15; i++) push_note(i + 1, 1);
        for (int i = 0; i < BD; i++) exp_f.push_back(16);
        for (int i = 0; i < GC; i++) exp_f.push_back(0);
        run_exp("full");
        done_check("full", 15);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("full_no_replay_busy", busy, 0);
            chk("full_no_replay_freq", frequency_control, 0);
        end

        // reset during playback of entry 1
        start_play("rstmid");
        for (int i = 0; i < 9; i++) tick();
        chk("rstmid_idx_before", note_index, 1);
        chk("rstmid_freq_before", frequency_control, 2);
        rst_n = 1'b0;
        tick();
        tick();
        chk("rstmid_freq", frequency_control, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_idx", note_index, 0);
        rst_n = 1'b1;
        tick();

`ifdef SEQ_LOOP_EN
        wr(0, 7, 1);
        wr(1, 0, 0);
        loop = 1'b1;
        start_play("loop");
        for (int r = 0; r < 3; r++) begin
            push_note(7, 1);
            exp_f.push_back(0);
        end
        run_exp("loop");
        loop = 1'b0;
        push_note(7, 1);
        run_exp("loop_off");
        done_check("loop_off", 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
